// File: rtl/uart_rx_fifo_ctrl_pkg.sv
// Shared types and constants for the UART receive FIFO controller: entry layout,
// trigger-level encodings, sticky line-status flags and the character-timeout limit.
package uart_rx_fifo_ctrl_pkg;

  localparam int ENTRY_W         = 11;
  localparam int PE_BIT          = 8;
  localparam int FE_BIT          = 9;
  localparam int BRK_BIT         = 10;
  localparam int TOUT_PER_BIT    = 64;
  localparam int FRAME_BITS_BASE = 7;  // start + 5 data + 1 stop

  typedef enum logic [1:0] {
    TRIG_1  = 2'd0,
    TRIG_4  = 2'd1,
    TRIG_8  = 2'd2,
    TRIG_14 = 2'd3
  } trig_e;

  typedef struct packed {
    logic       brk;
    logic       fe;
    logic       pe;
    logic [7:0] dat;
  } entry_t;

  typedef struct packed {
    logic ovr;
    logic pe;
    logic fe;
    logic brk;
  } lsr_t;

  function automatic logic [4:0] trig_threshold(input trig_e lvl);
    case (lvl)
      TRIG_1:  return 5'd1;
      TRIG_4:  return 5'd4;
      TRIG_8:  return 5'd8;
      default: return 5'd14;
    endcase
  endfunction

  // Character timeout in 16x ticks: four character times of the configured frame.
  function automatic logic [9:0] timeout_limit(input logic [5:0] cr);
    logic [3:0] frame_bits;
    frame_bits = 4'(FRAME_BITS_BASE) + {2'b00, cr[1:0]} + {3'b000, cr[3]} + {3'b000, cr[2]};
    return 10'(frame_bits) * 10'(TOUT_PER_BIT);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_ctrl_sync_fifo.sv
// Show-ahead synchronous FIFO: head visible the cycle after the push, pop takes effect at the edge.
// Guards itself against push when full (unless popping) and pop when empty; clr has priority.
module sync_fifo_sa #(
  parameter int WIDTH      = 11,
  parameter int DEPTH_LOG2 = 4,
  parameter int TAG_LSB    = 8,
  localparam int DEPTH     = 1 << DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [WIDTH-1:0]      wdat_i,
  output logic [WIDTH-1:0]      rdat_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic [DEPTH-1:0]      valid_o,
  output logic [DEPTH-1:0]      tag_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int PTR_W = DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o & ~clr_i;
  assign do_push = push_i & (~full_o | do_pop) & ~clr_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (do_pop) begin
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      valid_d[rd_ptr_q] = 1'b0;
    end
    // Push after pop so a full-FIFO push/pop on the same slot leaves it valid.
    if (do_push) begin
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      valid_d[wr_ptr_q] = 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      valid_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdat_i;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_tag
    assign tag_o[i] = |mem_q[i][WIDTH-1:TAG_LSB];
  end

  assign rdat_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// Receive-side UART controller: tagged RX FIFO, sticky line status, timeout and RX interrupts.
// Push visible next cycle; fifoFull backpressures the receiver; interrupts are registered (+1 cycle).
module uart_rx_fifo_ctrl
  import uart_rx_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  baudRateX16Tick,
  input  logic [5:0]            controlReg,
  input  logic                  fifoEnable,
  input  logic                  fifoClear,
  input  logic [1:0]            triggerLevel,
  input  logic                  rxWe,
  input  logic [7:0]            rxData,
  input  logic                  rxFrameError,
  input  logic                  rxParityError,
  input  logic                  rxBreak,
  input  logic                  rxOverrun,
  output logic                  fifoFull,
  input  logic                  readPop,
  input  logic                  lsrRead,
  output logic [7:0]            headData,
  output logic                  dataReady,
  output logic [DEPTH_LOG2:0]   fillLevel,
  output logic                  lsrOverrun,
  output logic                  lsrParity,
  output logic                  lsrFrame,
  output logic                  lsrBreak,
  output logic                  fifoErr,
  output logic                  irqRxData,
  output logic                  irqLineStatus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  logic [ENTRY_W-1:0] fifo_rdat;
  logic [CNT_W-1:0]   fifo_count;
  logic [DEPTH-1:0]   fifo_valid, fifo_tag;
  logic               fifo_full, fifo_empty;
  entry_t             wr_entry, head;
  logic               flush, do_push, do_pop;
  logic [CNT_W-1:0]   thr;
  logic [9:0]         tout_limit;
  logic               timeout;

  logic               fifo_en_q, ovr_prev_q, arr_q, arr_d, irq_q, irq_d;
  logic [9:0]         tout_cnt_q, tout_cnt_d;
  lsr_t               sticky_q, sticky_d, lsr_set;

  // Dropping fifoEnable flushes; while it stays low the FIFO runs with capacity one.
  assign flush    = fifoClear | (fifo_en_q & ~fifoEnable);
  assign fifoFull = fifoEnable ? fifo_full : ~fifo_empty;
  assign do_pop   = readPop & ~fifo_empty & ~flush;
  assign do_push  = rxWe & (~fifoFull | do_pop) & ~flush;

  assign wr_entry = '{brk: rxBreak, fe: rxFrameError, pe: rxParityError, dat: rxData};

  sync_fifo_sa #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .TAG_LSB    (PE_BIT)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .clr_i   (flush),
    .push_i  (do_push),
    .pop_i   (do_pop),
    .wdat_i  (wr_entry),
    .rdat_o  (fifo_rdat),
    .count_o (fifo_count),
    .valid_o (fifo_valid),
    .tag_o   (fifo_tag),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head = entry_t'(fifo_rdat);

  // arr_q marks the first cycle a new entry sits at the head, so error tags set the
  // sticky bits once per entry and an lsrRead is not undone by a lingering head.
  assign arr_d = ~flush & ((do_pop & ((fifo_count > CNT_W'(1)) | do_push)) |
                           (do_push & fifo_empty));

  always_comb begin
    lsr_set     = '0;
    lsr_set.ovr = rxOverrun & ~ovr_prev_q;
    lsr_set.pe  = arr_q & head.pe;
    lsr_set.fe  = arr_q & head.fe;
    lsr_set.brk = arr_q & head.brk;
    sticky_d    = lsr_t'(lsr_set | (lsrRead ? lsr_t'('0) : sticky_q));
  end

  assign tout_limit = timeout_limit(controlReg);
  assign timeout    = ~fifo_empty & (tout_cnt_q >= tout_limit);

  always_comb begin
    tout_cnt_d = tout_cnt_q;
    if (flush | do_push | do_pop | fifo_empty) begin
      tout_cnt_d = '0;
    end else if (tout_cnt_q < tout_limit && baudRateX16Tick) begin
      tout_cnt_d = tout_cnt_q + 10'd1;
    end
  end

  assign thr   = fifoEnable ? CNT_W'(trig_threshold(trig_e'(triggerLevel))) : CNT_W'(1);
  assign irq_d = (fifo_count >= thr) | timeout;

  always_ff @(posedge clock) begin
    if (!reset) begin
      fifo_en_q  <= 1'b0;
      ovr_prev_q <= 1'b0;
      arr_q      <= 1'b0;
      irq_q      <= 1'b0;
      tout_cnt_q <= '0;
      sticky_q   <= '0;
    end else begin
      fifo_en_q  <= fifoEnable;
      ovr_prev_q <= rxOverrun;
      arr_q      <= arr_d;
      irq_q      <= irq_d;
      tout_cnt_q <= tout_cnt_d;
      sticky_q   <= sticky_d;
    end
  end

  assign headData      = head.dat;
  assign dataReady     = ~fifo_empty;
  assign fillLevel     = fifo_count;
  assign lsrOverrun    = sticky_q.ovr;
  assign lsrParity     = sticky_q.pe;
  assign lsrFrame      = sticky_q.fe;
  assign lsrBreak      = sticky_q.brk;
  assign irqLineStatus = |sticky_q;
  assign fifoErr       = |(fifo_valid & fifo_tag);
  assign irqRxData     = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Directed bench for uart_rx_fifo_ctrl: inputs change 1 time unit after the rising edge,
// outputs are sampled at the same point, i.e. they reflect the state after that edge.
module tb_uart_rx_fifo_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic [5:0] cr = 6'b000011;
  logic       fifoEnable = 1'b1;
  logic       fifoClear = 1'b0;
  logic [1:0] trig = 2'd1;
  logic       rxWe = 1'b0;
  logic [7:0] rxData = 8'h00;
  logic       fe = 1'b0, pe = 1'b0, brk = 1'b0, ovr = 1'b0;
  logic       readPop = 1'b0, lsrRead = 1'b0;

  logic       fifoFull, dataReady, lsrOverrun, lsrParity, lsrFrame, lsrBreak;
  logic       fifoErr, irqRxData, irqLineStatus;
  logic [7:0] headData;
  logic [4:0] fillLevel;

  int total = 0;
  int bad   = 0;

  uart_rx_fifo_ctrl #(.DEPTH_LOG2(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .baudRateX16Tick (tick),
    .controlReg      (cr),
    .fifoEnable      (fifoEnable),
    .fifoClear       (fifoClear),
    .triggerLevel    (trig),
    .rxWe            (rxWe),
    .rxData          (rxData),
    .rxFrameError    (fe),
    .rxParityError   (pe),
    .rxBreak         (brk),
    .rxOverrun       (ovr),
    .fifoFull        (fifoFull),
    .readPop         (readPop),
    .lsrRead         (lsrRead),
    .headData        (headData),
    .dataReady       (dataReady),
    .fillLevel       (fillLevel),
    .lsrOverrun      (lsrOverrun),
    .lsrParity       (lsrParity),
    .lsrFrame        (lsrFrame),
    .lsrBreak        (lsrBreak),
    .fifoErr         (fifoErr),
    .irqRxData       (irqRxData),
    .irqLineStatus   (irqLineStatus)
  );

  always #5 clock = ~clock;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic p, input logic f, input logic b);
    rxWe = 1'b1; rxData = d; pe = p; fe = f; brk = b;
    cyc(1);
    rxWe = 1'b0; pe = 1'b0; fe = 1'b0; brk = 1'b0;
  endtask

  task automatic pop();
    readPop = 1'b1;
    cyc(1);
    readPop = 1'b0;
  endtask

  task automatic lsr_rd();
    lsrRead = 1'b1;
    cyc(1);
    lsrRead = 1'b0;
  endtask

  initial begin
    // Reset state
    cyc(3);
    chk("rst_fill", fillLevel, 0);
    chk("rst_dr", dataReady, 0);
    chk("rst_head", headData, 0);
    chk("rst_full", fifoFull, 0);
    chk("rst_irq", irqRxData, 0);
    chk("rst_lsi", irqLineStatus, 0);
    chk("rst_err", fifoErr, 0);
    reset = 1'b1;
    cyc(1);

    // 1: show-ahead ordering
    push(8'h41, 0, 0, 0);
    push(8'h42, 0, 0, 0);
    chk("t1_dr", dataReady, 1);
    chk("t1_head", headData, 8'h41);
    chk("t1_fill", fillLevel, 2);
    pop();
    chk("t1_head2", headData, 8'h42);
    pop();
    chk("t1_empty", dataReady, 0);
    chk("t1_head0", headData, 0);

    // 2: trigger level 4
    trig = 2'd1;
    push(8'h01, 0, 0, 0);
    push(8'h02, 0, 0, 0);
    push(8'h03, 0, 0, 0);
    cyc(2);
    chk("t2_irq3", irqRxData, 0);
    push(8'h04, 0, 0, 0);
    chk("t2_irq_lag", irqRxData, 0);
    cyc(1);
    chk("t2_irq4", irqRxData, 1);
    pop();
    cyc(1);
    chk("t2_irq_pop", irqRxData, 0);
    fifoClear = 1'b1;
    cyc(1);
    fifoClear = 1'b0;
    chk("t2_clr", fillLevel, 0);

    // 3: 8N1 timeout, limit 640 ticks; tick every cycle, irq registered one cycle later
    cr = 6'b000011;
    tick = 1'b1;
    push(8'h55, 0, 0, 0);
    cyc(640);
    chk("t3_irq_early", irqRxData, 0);
    cyc(1);
    chk("t3_irq_tout", irqRxData, 1);
    pop();
    cyc(1);
    chk("t3_irq_pop", irqRxData, 0);
    tick = 1'b0;

    // 4: fill, drop on full, overrun edge
    for (int i = 0; i < 16; i++) begin
      rxWe = 1'b1;
      rxData = 8'(8'h80 + i);
      cyc(1);
    end
    rxWe = 1'b0;
    chk("t4_full", fifoFull, 1);
    chk("t4_fill16", fillLevel, 16);
    push(8'hAA, 0, 0, 0);
    chk("t4_drop_fill", fillLevel, 16);
    chk("t4_drop_head", headData, 8'h80);
    ovr = 1'b1;
    cyc(1);
    chk("t4_ovr", lsrOverrun, 1);
    chk("t4_lsi", irqLineStatus, 1);
    lsr_rd();
    chk("t4_ovr_clr", lsrOverrun, 0);
    chk("t4_lsi_clr", irqLineStatus, 0);
    ovr = 1'b0;

    // 6a: push+pop while full, then clear beats push
    rxWe = 1'b1; rxData = 8'hCC; readPop = 1'b1;
    cyc(1);
    rxWe = 1'b0; readPop = 1'b0;
    chk("t6_pp_fill", fillLevel, 16);
    chk("t6_pp_head", headData, 8'h81);
    fifoClear = 1'b1; rxWe = 1'b1; rxData = 8'hDD;
    cyc(1);
    fifoClear = 1'b0; rxWe = 1'b0;
    chk("t6_clr_fill", fillLevel, 0);
    chk("t6_clr_dr", dataReady, 0);

    // 5: parity tag behind two clean entries
    push(8'h10, 0, 0, 0);
    push(8'h11, 0, 0, 0);
    push(8'h12, 1, 0, 0);
    chk("t5_err", fifoErr, 1);
    chk("t5_pe_early", lsrParity, 0);
    pop();
    pop();
    cyc(1);
    chk("t5_pe_head", lsrParity, 1);
    chk("t5_lsi", irqLineStatus, 1);
    chk("t5_head", headData, 8'h12);
    pop();
    chk("t5_err_clr", fifoErr, 0);
    chk("t5_pe_stays", lsrParity, 1);
    lsr_rd();
    chk("t5_pe_clr", lsrParity, 0);

    // frame+break entry arriving straight at head; read clears without re-set
    push(8'h20, 0, 1, 1);
    cyc(1);
    chk("fb_fe", lsrFrame, 1);
    chk("fb_brk", lsrBreak, 1);
    lsr_rd();
    chk("fb_fe_clr", lsrFrame, 0);
    pop();

    // fifoEnable 1->0 flushes, then depth-1 mode
    push(8'h30, 0, 0, 0);
    push(8'h31, 0, 0, 0);
    fifoEnable = 1'b0;
    cyc(1);
    chk("en_flush", fillLevel, 0);
    push(8'h31, 0, 0, 0);
    chk("d1_full", fifoFull, 1);
    cyc(1);
    chk("d1_irq", irqRxData, 1);
    push(8'h32, 0, 0, 0);
    chk("d1_fill", fillLevel, 1);
    chk("d1_head", headData, 8'h31);
    fifoEnable = 1'b1;
    pop();

    // 6b: reset mid-stream
    trig = 2'd0;
    push(8'h40, 1, 0, 0);
    rxWe = 1'b1; rxData = 8'h41;
    cyc(2);
    ovr = 1'b1;
    cyc(1);
    chk("t6_pre_irq", irqRxData, 1);
    chk("t6_pre_pe", lsrParity, 1);
    reset = 1'b0;
    cyc(1);
    chk("t6_rst_fill", fillLevel, 0);
    chk("t6_rst_dr", dataReady, 0);
    chk("t6_rst_head", headData, 0);
    chk("t6_rst_full", fifoFull, 0);
    chk("t6_rst_irq", irqRxData, 0);
    chk("t6_rst_lsi", irqLineStatus, 0);
    chk("t6_rst_pe", lsrParity, 0);
    chk("t6_rst_ovr", lsrOverrun, 0);
    chk("t6_rst_err", fifoErr, 0);
    rxWe = 1'b0; ovr = 1'b0; reset = 1'b1;
    cyc(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
